// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding and FIFO entry layout.
// The entry carries a misalign bit that is only ever set when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int PC_MAX_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // pc is sized for the widest supported PC; the top keeps only PC_WIDTH bits
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
        logic                misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO with push/pop/clear; head is a registered copy so it holds its value when empty.
// Push and pop in the same cycle are accepted, including when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output fetch_entry_t                 head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [BUF_DEPTH];
    fetch_entry_t     mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_mid;
    fetch_entry_t     head_q, head_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        do_pop    = pop && (count_q != '0);
        count_mid = count_q - CNT_W'(do_pop);
        do_push   = push && (count_mid < CNT_W'(BUF_DEPTH));
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_mid + CNT_W'(do_push);
            // next head: an already-stored entry, or the incoming one when it lands in an empty FIFO
            if (count_mid != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (do_push) begin
                head_d = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, buffers results for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds if_misalign and word-aligns redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_WIDTH  = 9,
    parameter int          BUF_DEPTH = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCSel,
    input  logic [31:0]         PCBranch,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                if_misalign
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] target;
    logic                push;
    logic                pop;
    logic                clear;
    logic                issue;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      fill_idle;
    logic [CNT_W:0]      fill_wait;
    logic                room_idle;
    logic                room_wait;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign target = {PCBranch[PC_WIDTH-1:2], 2'b00};
`else
    assign target = PCBranch[PC_WIDTH-1:0];
`endif

    assign pop = if_valid & if_ready;

    // occupancy after this cycle's push/pop decides whether another request may go out
    assign fill_idle = {1'b0, count} - (CNT_W+1)'(pop);
    assign fill_wait = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    assign room_idle = fill_idle < (CNT_W+1)'(BUF_DEPTH);
    assign room_wait = fill_wait < (CNT_W+1)'(BUF_DEPTH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        push    = 1'b0;
        clear   = 1'b0;
        issue   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        if (PCSel) begin
            clear = 1'b1;
            pc_d  = target;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d = |PCBranch[1:0];
`endif
            if (state_q == WAIT) begin
                state_d = imem_rvalid ? IDLE : DROP;
            end else if (state_q == DROP && imem_rvalid) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    issue = room_idle;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = IDLE;
                        issue   = room_wait;
`ifdef FETCH_MISALIGN_CHECK_EN
                        mis_d   = 1'b0;
`endif
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (issue) begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                pc_d    = pc_q + PC_WIDTH'(INSTR_BYTES);
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PC_WIDTH'(RESET_PC);
            req_q   <= 1'b0;
            addr_q  <= PC_WIDTH'(RESET_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // the outstanding request's address is the PC recorded with its response
    always_comb begin
        push_entry          = '0;
        push_entry.pc       = PC_MAX_W'(addr_q);
        push_entry.instr    = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
        push_entry.misalign = mis_q;
`else
        push_entry.misalign = 1'b0;
`endif
    end

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (clear),
        .count     (count),
        .head      (head)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = (count != '0);
    assign if_pc     = head.pc[PC_WIDTH-1:0];
    assign if_instr  = head.instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign if_misalign = head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;

    localparam int PCW      = 9;
    localparam int DEPTH    = 2;
    localparam int RESET_PC = 0;

    logic           clk = 1'b0;
    logic           reset;
    logic           PCSel;
    logic [31:0]    PCBranch;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_rvalid;
    logic [31:0]    imem_rdata;
    logic           if_valid;
    logic           if_ready;
    logic [PCW-1:0] if_pc;
    logic [31:0]    if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic           if_misalign;
`endif

    fetch_unit #(
        .PC_WIDTH  (PCW),
        .BUF_DEPTH (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSel       (PCSel),
        .PCBranch    (PCBranch),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .if_misalign (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCW-1:0] pc;
        logic [31:0]    instr;
        logic           mis;
    } ent_t;

    ent_t           exp_q[$];
    ent_t           pop_log[$];
    logic [PCW-1:0] req_log[$];
    ent_t           shown;
    logic [PCW-1:0] m_pc;
    logic           m_mis;

    bit             mem_pending;
    int             mem_cnt;
    logic [PCW-1:0] mem_pc;
    bit             mem_keep;

    bit             in_reset;
    bit             rel_req;
    int             cyc;
    int             first_req_cyc, second_req_cyc, first_valid_cyc;
    int             n_push;
    int             ready_pct, lat_lo, lat_hi, redir_pct;
    bit             force_sel;
    bit             sel_on_rvalid;
    logic [31:0]    force_tgt;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock of bench activity, executed at the falling edge
    task automatic tick();
        logic           rv;
        logic           rv_keep;
        logic [PCW-1:0] rv_pc;
        logic [31:0]    rd;
        logic           sel;
        logic [31:0]    tgt;
        logic           rdy;
        ent_t           e;
        @(negedge clk);
        cyc++;
        rv = 1'b0; rv_keep = 1'b0; rv_pc = '0;
        rd = $urandom; sel = 1'b0; tgt = '0;
        if (in_reset) begin
            chk("rst_req",   imem_req,  0);
            chk("rst_addr",  imem_addr, RESET_PC);
            chk("rst_valid", if_valid,  0);
            chk("rst_pc",    if_pc,     0);
            chk("rst_instr", if_instr,  0);
        end else begin
            chk("valid", if_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) shown = exp_q[0];
            chk("if_pc",    if_pc,    shown.pc);
            chk("if_instr", if_instr, shown.instr);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("if_misalign", if_misalign, shown.mis);
`endif
            if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (imem_req) chk("one_outstanding", mem_pending, 0);
        end
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                rv = 1'b1; rv_keep = mem_keep; rv_pc = mem_pc; mem_pending = 0;
            end
        end
        if (!in_reset && imem_req) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("room_for_response", exp_q.size() < DEPTH, 1);
            req_log.push_back(imem_addr);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            else if (second_req_cyc < 0) second_req_cyc = cyc;
            mem_pending = 1;
            mem_cnt     = $urandom_range(lat_hi, lat_lo);
            mem_pc      = m_pc;
            mem_keep    = 1;
            m_pc        = m_pc + PCW'(4);
        end
        rdy = ($urandom_range(99) < ready_pct);
        if (!in_reset) begin
            if (force_sel) begin
                sel = 1'b1; tgt = force_tgt; force_sel = 0;
            end else if (sel_on_rvalid && rv) begin
                sel = 1'b1; tgt = force_tgt; sel_on_rvalid = 0;
            end else if ($urandom_range(99) < redir_pct) begin
                sel = 1'b1; tgt = $urandom;
            end
            if (exp_q.size() != 0 && rdy) begin
                e = exp_q.pop_front();
                pop_log.push_back(e);
            end
            if (rv && rv_keep && !sel) begin
                e.pc = rv_pc; e.instr = rd; e.mis = m_mis;
                m_mis = 1'b0;
                exp_q.push_back(e);
                n_push++;
            end
            if (sel) begin
                exp_q.delete();
                mem_keep = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
                m_pc  = tgt[PCW-1:0] & ~PCW'(3);
                m_mis = |tgt[1:0];
`else
                m_pc  = tgt[PCW-1:0];
`endif
            end
        end
        if (in_reset && rel_req && !mem_pending) begin
            in_reset = 0; rel_req = 0;
        end
        reset       = in_reset;
        PCSel       = sel;
        PCBranch    = tgt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        if_ready    = rdy;
    endtask

    // a still-pending memory response is left to arrive during or right at reset release
    task automatic do_reset();
        in_reset = 1; rel_req = 0;
        reset = 1'b1; PCSel = 1'b0; imem_rvalid = 1'b0;
        exp_q.delete(); pop_log.delete(); req_log.delete();
        m_pc = PCW'(RESET_PC); m_mis = 1'b0;
        shown = '{pc: '0, instr: '0, mis: 1'b0};
        mem_keep = 0;
        first_req_cyc = -1; second_req_cyc = -1; first_valid_cyc = -1;
        n_push = 0;
        repeat (3) tick();
        rel_req = 1;
        for (int i = 0; i < 10 && in_reset; i++) tick();
        if (in_reset) begin
            chk("reset_release_timeout", 0, 1);
            in_reset = 0; rel_req = 0; reset = 1'b0;
        end
    endtask

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 50 && req_log.size() < n; i++) tick();
        if (req_log.size() < n) chk("wait_req_timeout", req_log.size(), n);
    endtask

    initial begin
        int idx;
        int pidx;
        n_checks = 0; n_errors = 0; cyc = 0;
        reset = 1'b1; PCSel = 1'b0; PCBranch = '0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        mem_pending = 0; mem_cnt = 0; mem_pc = '0; mem_keep = 0;
        force_sel = 0; sel_on_rvalid = 0; force_tgt = '0;
        ready_pct = 100; lat_lo = 1; lat_hi = 1; redir_pct = 0;
        in_reset = 1; rel_req = 0;

        // streaming from reset, latency 1, always ready
        do_reset();
        repeat (12) tick();
        if (req_log.size() >= 3) begin
            chk("t1_addr0", req_log[0], 9'h000);
            chk("t1_addr1", req_log[1], 9'h004);
            chk("t1_addr2", req_log[2], 9'h008);
        end else chk("t1_req_count", req_log.size(), 3);
        chk("t1_req_to_valid", first_valid_cyc - first_req_cyc, 2);
        chk("t1_req_spacing", second_req_cyc - first_req_cyc, 2);
        if (pop_log.size() >= 1) chk("t1_first_pc", pop_log[0].pc, 9'h000);
        else chk("t1_pop_count", pop_log.size(), 1);

        // downstream stalled: exactly DEPTH fetches, then drain in order
        ready_pct = 0;
        do_reset();
        repeat (10) tick();
        chk("t2_pushes", n_push, DEPTH);
        chk("t2_reqs", req_log.size(), DEPTH);
        chk("t2_req_idle", imem_req, 0);
        ready_pct = 100;
        repeat (6) tick();
        if (pop_log.size() >= 2) begin
            chk("t2_drain0", pop_log[0].pc, 9'h000);
            chk("t2_drain1", pop_log[1].pc, 9'h004);
        end else chk("t2_pop_count", pop_log.size(), 2);

        // response still in flight when the redirect hits, latency 3
        lat_lo = 3; lat_hi = 3;
        do_reset();
        wait_reqs(1);
        force_sel = 1; force_tgt = 32'h0000_0040;
        idx = req_log.size(); pidx = pop_log.size();
        repeat (20) tick();
        if (req_log.size() > idx) chk("t3_next_addr", req_log[idx], 9'h040);
        else chk("t3_req_count", req_log.size(), idx + 1);
        if (pop_log.size() > pidx) chk("t3_first_pc", pop_log[pidx].pc, 9'h040);
        else chk("t3_pop_count", pop_log.size(), pidx + 1);

        // redirect in the same cycle as the response
        lat_lo = 1; lat_hi = 1;
        do_reset();
        sel_on_rvalid = 1; force_tgt = 32'h0000_0100;
        for (int i = 0; i < 20 && sel_on_rvalid; i++) tick();
        chk("t4_redirect_seen", sel_on_rvalid, 0);
        idx = req_log.size();
        tick();
        chk("t4_valid_after", if_valid, 0);
        repeat (6) tick();
        if (req_log.size() > idx) chk("t4_next_addr", req_log[idx], 9'h100);
        else chk("t4_req_count", req_log.size(), idx + 1);

        // PC wrap at the top of the address space
        do_reset();
        wait_reqs(1);
        force_sel = 1; force_tgt = 32'h0000_01FC;
        idx = req_log.size();
        repeat (12) tick();
        if (req_log.size() > idx + 1) begin
            chk("t5_addr_top", req_log[idx], 9'h1FC);
            chk("t5_addr_wrap", req_log[idx+1], 9'h000);
        end else chk("t5_req_count", req_log.size(), idx + 2);

`ifdef FETCH_MISALIGN_CHECK_EN
        do_reset();
        wait_reqs(1);
        force_sel = 1; force_tgt = 32'h0000_0022;
        idx = req_log.size(); pidx = pop_log.size();
        repeat (12) tick();
        if (req_log.size() > idx) chk("t6_addr", req_log[idx], 9'h020);
        else chk("t6_req_count", req_log.size(), idx + 1);
        if (pop_log.size() > pidx + 1) begin
            chk("t6_mis_first",  pop_log[pidx].mis,   1);
            chk("t6_mis_second", pop_log[pidx+1].mis, 0);
        end else chk("t6_pop_count", pop_log.size(), pidx + 2);
`endif

        // randomized traffic with a reset dropped in mid-stream
        ready_pct = 70; lat_lo = 1; lat_hi = 4; redir_pct = 5;
        do_reset();
        repeat (1500) tick();
        lat_lo = 3; lat_hi = 4;
        wait_reqs(req_log.size() + 1);
        lat_lo = 1;
        do_reset();
        repeat (1500) tick();
        chk("random_progress", pop_log.size() > 100, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
